// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared constants, command codes and FSM states for the matrix sequencer
package matrix_pkg;

    localparam int FRAC_BITS_DEFAULT = 16;

    // Byte offsets into math space
    localparam logic [11:0] MI_BASE     = 12'h600;
    localparam logic [11:0] MV_BASE     = 12'h640;
    localparam logic [11:0] MO_BASE     = 12'h660;
    localparam logic [11:0] NFRAC_HI    = 12'h680;
    localparam logic [11:0] NFRAC_LO    = 12'h684;
    localparam logic [11:0] STATUS_ADDR = 12'h7F4;
    localparam logic [11:0] START_ADDR  = 12'h7F8;
    localparam logic [11:0] CLEAR_ADDR  = 12'h7FC;

    typedef enum logic [1:0] {
        CMD_MUL4 = 2'd0,
        CMD_MUL3 = 2'd1,
        CMD_COPY = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/matrix_mac.sv
// rtl/matrix_mac.sv - signed 32x32 multiplier feeding a wrapping 64-bit accumulator
module matrix_mac (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_acc
);

    logic signed [63:0] w_a;
    logic signed [63:0] w_b;
    logic signed [63:0] w_prod;
    logic        [63:0] r_acc;

    assign w_a    = {{32{i_a[31]}}, i_a};
    assign w_b    = {{32{i_b[31]}}, i_b};
    assign w_prod = w_a * w_b;
    assign o_acc  = r_acc;

    // Accumulate one product per enabled cycle; clr restarts the sum with this product
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= (i_clr ? 64'd0 : r_acc) + w_prod;
        end else if (i_clr) begin
            r_acc <= '0;
        end
    end

endmodule

// File: rtl/matrix_sequencer.sv
// rtl/matrix_sequencer.sv - register file, decode and row/column MAC schedule for matrix-by-vector multiply
module matrix_sequencer
    import matrix_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [11:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        busy,
    output logic        done
);

    logic [31:0] r_mi [0:15];
    logic [31:0] r_mv [0:3];
    logic [31:0] r_mo [0:3];
    logic [31:0] r_tmp [0:3];
    logic [31:0] r_nfrac_hi;
    logic [31:0] r_nfrac_lo;
    logic        r_cmd_err;
    logic        r_wr_err;
    logic [31:0] r_dout;
    logic [1:0]  r_row;
    logic [1:0]  r_col;
    logic        r_n3;
    state_t      r_state;
    state_t      w_next;

    logic        w_is_mi, w_is_mv, w_is_mo, w_is_nhi, w_is_nlo;
    logic        w_is_status, w_is_start, w_is_clear, w_is_operand;
    logic        w_busy, w_start, w_go, w_copy;
    logic [1:0]  w_last;
    cmd_t        w_cmd;
    logic [63:0] w_acc;
    logic signed [63:0] w_shifted;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_is_mi      = (cpu_addr[11:6] == MI_BASE[11:6]);
    assign w_is_mv      = (cpu_addr[11:4] == MV_BASE[11:4]);
    assign w_is_mo      = (cpu_addr[11:4] == MO_BASE[11:4]);
    assign w_is_nhi     = (cpu_addr[11:2] == NFRAC_HI[11:2]);
    assign w_is_nlo     = (cpu_addr[11:2] == NFRAC_LO[11:2]);
    assign w_is_status  = (cpu_addr[11:2] == STATUS_ADDR[11:2]);
    assign w_is_start   = (cpu_addr[11:2] == START_ADDR[11:2]);
    assign w_is_clear   = (cpu_addr[11:2] == CLEAR_ADDR[11:2]);
    assign w_is_operand = w_is_mi | w_is_mv | w_is_nhi | w_is_nlo;

    // DONE counts as idle so a new command can be taken back-to-back
    assign w_busy  = (r_state == ST_MAC) || (r_state == ST_STORE);
    assign w_cmd   = cmd_t'(cpu_din[1:0]);
    assign w_start = cpu_wr && w_is_start && !w_busy;
    assign w_go    = w_start && ((w_cmd == CMD_MUL4) || (w_cmd == CMD_MUL3));
    assign w_copy  = w_start && (w_cmd == CMD_COPY);
    assign w_last  = r_n3 ? 2'd2 : 2'd3;

    assign w_shifted = $signed(w_acc) >>> FRAC_BITS;
    assign w_unused  = ^{cpu_addr[1:0], w_shifted[63:32]};

    assign busy     = w_busy;
    assign done     = (r_state == ST_DONE);
    assign cpu_dout = r_dout;

    matrix_mac u_mac (
        .i_clk   (clock),
        .i_reset (reset),
        .i_clr   ((r_state == ST_MAC) && (r_col == 2'd0)),
        .i_en    (r_state == ST_MAC),
        .i_a     (r_mi[{r_row, r_col}]),
        .i_b     (r_mv[r_col]),
        .o_acc   (w_acc)
    );

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state: COPY reuses DONE for its one-cycle completion pulse
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_go)        w_next = ST_MAC;
                else if (w_copy) w_next = ST_DONE;
                else             w_next = ST_IDLE;
            end
            ST_MAC:   if (r_col == w_last) w_next = ST_STORE;
            ST_STORE: w_next = (r_row == w_last) ? ST_DONE : ST_MAC;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Row/column schedule counters and matrix size latch
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
            r_n3  <= 1'b0;
        end else if (w_go) begin
            r_row <= '0;
            r_col <= '0;
            r_n3  <= (w_cmd == CMD_MUL3);
        end else if (r_state == ST_MAC) begin
            r_col <= (r_col == w_last) ? 2'd0 : r_col + 2'd1;
        end else if (r_state == ST_STORE) begin
            r_row <= r_row + 2'd1;
        end
    end

    // Operand registers: frozen while a compute is in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_mi[i] <= '0;
            for (int i = 0; i < 4; i++)  r_mv[i] <= '0;
            r_nfrac_hi <= '0;
            r_nfrac_lo <= '0;
        end else if (cpu_wr && !w_busy) begin
            if (w_is_mi)  r_mi[cpu_addr[5:2]] <= cpu_din;
            if (w_is_mv)  r_mv[cpu_addr[3:2]] <= cpu_din;
            if (w_is_nhi) r_nfrac_hi <= cpu_din;
            if (w_is_nlo) r_nfrac_lo <= cpu_din;
        end
    end

    // Sticky error flags
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cmd_err <= 1'b0;
            r_wr_err  <= 1'b0;
        end else if (cpu_wr) begin
            if (w_is_operand && w_busy) r_wr_err <= 1'b1;
            if (w_is_start && (w_busy || (w_cmd == CMD_RSVD))) r_cmd_err <= 1'b1;
            if (w_is_clear) begin
                r_cmd_err <= 1'b0;
                r_wr_err  <= 1'b0;
            end
        end
    end

    // Result double buffer: row sums land in tmp, START/COPY publish tmp to MO
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_mo[i]  <= '0;
                r_tmp[i] <= '0;
            end
        end else begin
            if (w_go || w_copy) begin
                for (int i = 0; i < 4; i++) r_mo[i] <= r_tmp[i];
            end
            if (r_state == ST_STORE) r_tmp[r_row] <= w_shifted[31:0];
        end
    end

    // Read mux
    always_comb begin
        w_rdata = '0;
        if (w_is_mi)          w_rdata = r_mi[cpu_addr[5:2]];
        else if (w_is_mv)     w_rdata = r_mv[cpu_addr[3:2]];
        else if (w_is_mo)     w_rdata = r_mo[cpu_addr[3:2]];
        else if (w_is_nhi)    w_rdata = r_nfrac_hi;
        else if (w_is_nlo)    w_rdata = r_nfrac_lo;
        else if (w_is_status) w_rdata = {29'd0, r_wr_err, r_cmd_err, w_busy};
    end

    // Registered read data, held between reads
    always_ff @(posedge clock) begin
        if (reset)       r_dout <= '0;
        else if (cpu_rd) r_dout <= w_rdata;
    end

endmodule

// File: tb/tb_matrix_sequencer.sv
// tb/tb_matrix_sequencer.sv - self-checking bench for matrix_sequencer
module tb_matrix_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_din;
    logic [31:0] cpu_dout;
    logic        busy;
    logic        done;

    matrix_sequencer #(.FRAC_BITS(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .cpu_wr   (cpu_wr),
        .cpu_rd   (cpu_rd),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;

    logic [31:0] m_mi [16];
    logic [31:0] m_mv [4];
    logic [31:0] m_mo [4];
    logic [31:0] m_tmp [4];
    logic [31:0] m_pend [4];
    logic [31:0] m_nhi, m_nlo, m_dout;
    logic        m_cmd_err, m_wr_err, m_done;
    int          m_left;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", nm, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        logic [11:0] w;
        w = a & 12'hFFC;
        if (w >= 12'h600 && w <= 12'h63C) return m_mi[a[5:2]];
        if (w >= 12'h640 && w <= 12'h64C) return m_mv[a[3:2]];
        if (w >= 12'h660 && w <= 12'h66C) return m_mo[a[3:2]];
        if (w == 12'h680) return m_nhi;
        if (w == 12'h684) return m_nlo;
        if (w == 12'h7F4) return {29'd0, m_wr_err, m_cmd_err, (m_left > 0)};
        return 32'd0;
    endfunction

    // Whole matrix-by-vector product, committed to tmp when the schedule ends
    task automatic compute(input int n);
        for (int r = 0; r < 4; r++) begin
            longint acc;
            acc = 0;
            if (r < n) begin
                for (int c = 0; c < n; c++)
                    acc += longint'($signed(m_mi[r*4+c])) * longint'($signed(m_mv[c]));
                m_pend[r] = 32'(acc >>> 16);
            end else begin
                m_pend[r] = m_tmp[r];
            end
        end
    endtask

    task automatic model_step();
        logic        bpre;
        logic [11:0] w;
        bpre = (m_left > 0);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_mi[i] = '0;
            for (int i = 0; i < 4; i++) begin
                m_mv[i] = '0; m_mo[i] = '0; m_tmp[i] = '0; m_pend[i] = '0;
            end
            m_nhi = '0; m_nlo = '0; m_dout = '0;
            m_cmd_err = 1'b0; m_wr_err = 1'b0; m_done = 1'b0; m_left = 0;
            return;
        end
        m_done = 1'b0;
        if (cpu_rd) m_dout = m_read(cpu_addr);
        if (bpre) begin
            m_left--;
            if (m_left == 0) begin
                m_tmp  = m_pend;
                m_done = 1'b1;
            end
        end
        if (cpu_wr) begin
            w = cpu_addr & 12'hFFC;
            if ((w >= 12'h600 && w <= 12'h64C) || w == 12'h680 || w == 12'h684) begin
                if (bpre) m_wr_err = 1'b1;
                else if (w <= 12'h63C) m_mi[w[5:2]] = cpu_din;
                else if (w <= 12'h64C) m_mv[w[3:2]] = cpu_din;
                else if (w == 12'h680) m_nhi = cpu_din;
                else m_nlo = cpu_din;
            end else if (w == 12'h7F8) begin
                if (bpre) m_cmd_err = 1'b1;
                else case (cpu_din[1:0])
                    2'd0, 2'd1: begin
                        m_mo = m_tmp;
                        compute(cpu_din[1:0] == 2'd0 ? 4 : 3);
                        m_left = (cpu_din[1:0] == 2'd0) ? 20 : 12;
                    end
                    2'd2: begin m_mo = m_tmp; m_done = 1'b1; end
                    default: m_cmd_err = 1'b1;
                endcase
            end else if (w == 12'h7FC) begin
                m_cmd_err = 1'b0;
                m_wr_err  = 1'b0;
            end
        end
    endtask

    // Every cycle the DUT outputs must agree with the model
    always @(negedge clock) begin
        chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("dout", cpu_dout, m_dout);
    end

    task automatic cyc();
        @(posedge clock);
        model_step();
        cyc_cnt++;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_din = d;
        cyc();
        cpu_wr = 1'b0;
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input string nm);
        cpu_rd = 1'b1; cpu_addr = a;
        cyc();
        cpu_rd = 1'b0;
        chk(nm, cpu_dout, exp);
    endtask

    // Waits for the done pulse; reports edges elapsed since the START edge t0
    task automatic wait_done(input int t0, input int exp_dt, input string nm);
        int dt;
        dt = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done) begin dt = cyc_cnt - t0; break; end
        end
        chk(nm, dt, exp_dt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, nb;
        logic seen;
        reset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_din = '0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_dout", cpu_dout, 32'd0);

        // Identity 3x3
        wr(12'h600, 32'h0001_0000); wr(12'h614, 32'h0001_0000); wr(12'h628, 32'h0001_0000);
        wr(12'h640, 32'h0001_0000); wr(12'h644, 32'h0002_0000); wr(12'h648, 32'h0003_0000);
        wr(12'h7F8, 32'd1);
        t0 = cyc_cnt;
        nb = busy ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (done) break;
            if (busy) nb++;
        end
        chk("id3_busy_cycles", nb, 12);
        chk("id3_done_edge", cyc_cnt - t0, 12);
        wr(12'h7F8, 32'd2);
        rd_chk(12'h660, 32'h0001_0000, "id3_mo0");
        rd_chk(12'h664, 32'h0002_0000, "id3_mo1");
        rd_chk(12'h668, 32'h0003_0000, "id3_mo2");
        rd_chk(12'h66C, 32'h0000_0000, "id3_mo3");

        // MUL4x4: -1.0 * 2.5
        wr(12'h614, 32'd0); wr(12'h628, 32'd0); wr(12'h644, 32'd0); wr(12'h648, 32'd0);
        wr(12'h600, 32'hFFFF_0000); wr(12'h640, 32'h0002_8000);
        wr(12'h7F8, 32'd0);
        wait_done(cyc_cnt, 20, "m4_done_edge");
        wr(12'h7F8, 32'd2);
        rd_chk(12'h660, 32'hFFFD_8000, "m4_mo0");
        rd_chk(12'h664, 32'h0000_0000, "m4_mo1");

        // Double buffer: A then B
        wr(12'h7F8, 32'd1);
        wait_done(cyc_cnt, 12, "dbA_done_edge");
        wr(12'h640, 32'h0001_0000);
        wr(12'h7F8, 32'd1);
        t0 = cyc_cnt;
        rd_chk(12'h660, 32'hFFFD_8000, "db_mo0_is_A");
        wait_done(t0, 12, "dbB_done_edge");
        wr(12'h7F8, 32'd2);
        rd_chk(12'h660, 32'hFFFF_0000, "db_mo0_is_B");

        // Errors while busy
        wr(12'h7F8, 32'd1);
        t0 = cyc_cnt;
        wr(12'h7F8, 32'd0);
        wr(12'h640, 32'h0000_7777);
        rd_chk(12'h7F4, 32'h0000_0007, "busy_status");
        wait_done(t0, 12, "err_done_edge");
        wr(12'h7F8, 32'd2);
        rd_chk(12'h660, 32'hFFFF_0000, "stray_mo0");
        rd_chk(12'h640, 32'h0001_0000, "stray_mv0");
        wr(12'h7FC, 32'd0);
        rd_chk(12'h7F4, 32'h0000_0000, "cleared_status");

        // Read-only / unmapped / Nfrac / simultaneous write+read
        wr(12'h660, 32'd5);
        rd_chk(12'h660, 32'hFFFF_0000, "mo_readonly");
        rd_chk(12'h100, 32'd0, "unmapped");
        wr(12'h680, 32'h0000_ABCD);
        rd_chk(12'h680, 32'h0000_ABCD, "nfrac_hi");
        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 12'h644; cpu_din = 32'h0000_1234;
        cyc();
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        chk("wr_rd_old", cpu_dout, 32'd0);
        rd_chk(12'h644, 32'h0000_1234, "wr_rd_new");

        // Reserved command
        wr(12'h7F8, 32'd3);
        rd_chk(12'h7F4, 32'h0000_0002, "rsvd_status");
        repeat (4) cyc();
        wr(12'h7FC, 32'd0);

        // Reset in the middle of MUL4x4
        wr(12'h7F8, 32'd0);
        repeat (4) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_chk(12'h660 + 12'(4*i), 32'd0, "rst_mo");
            if (done) seen = 1'b1;
        end
        for (int i = 0; i < 24; i++) begin
            cyc();
            if (done) seen = 1'b1;
        end
        chk("rst_no_done", {31'd0, seen}, 32'd0);
        wr(12'h600, 32'hFFFF_0000); wr(12'h640, 32'h0002_8000);
        wr(12'h7F8, 32'd0);
        wait_done(cyc_cnt, 20, "post_rst_done_edge");
        wr(12'h7F8, 32'd2);
        rd_chk(12'h660, 32'hFFFD_8000, "post_rst_mo0");
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
